// File: rtl/bus_grant_if.sv
// bus_grant_if: client/server handshake bundle between the bus_grant_sequencer and its environment
interface bus_grant_if #(parameter int WEIGHT_W = 3);
  logic                    enable;
  logic [3:0]              client_rq;
  logic [4*WEIGHT_W-1:0]   weight_cfg;
  logic                    server_ack;
  logic                    server_req;
  logic [3:0]              client_gnt;
  logic [1:0]              address_to_be_served;
  logic [3:0]              client_done;
  logic                    busy;
  logic                    timeout_err;
  modport master (
    output enable, client_rq, weight_cfg, server_ack,
    input  server_req, client_gnt, address_to_be_served, client_done, busy, timeout_err
  );
  modport slave (
    input  enable, client_rq, weight_cfg, server_ack,
    output server_req, client_gnt, address_to_be_served, client_done, busy, timeout_err
  );
endinterface

// File: rtl/bus_grant_sequencer.sv
// bus_grant_sequencer: four-client round-robin bus grant with weighted bursts; BUS_GRANT_TIMEOUT_EN adds a no-ack abort
module bus_grant_sequencer #(
  parameter int WEIGHT_W       = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  bus_grant_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ARB, GRANT, RELEASE} state_t;
  state_t state, state_nx;
  logic [1:0]          ptr, win, pick;
  logic [WEIGHT_W-1:0] wt, cnt, wsel;
  logic                found, ack, more, tmo;
  logic [3:0]          gnt, done;
  logic [1:0]          addr;
  logic                req;
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = 3; k >= 0; k--)
      if (bus.client_rq[ptr + 2'(k)]) begin
        found = 1'b1;
        pick  = ptr + 2'(k);
      end
  end
  assign wsel = bus.weight_cfg[pick*WEIGHT_W +: WEIGHT_W];
  assign ack  = (state == GRANT) && bus.server_ack;
  assign more = bus.enable && bus.client_rq[win] && (({1'b0, cnt} + 1'b1) < {1'b0, wt});
`ifdef BUS_GRANT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  // an ack landing on the limit cycle wins over the timeout
  assign tmo = (state == GRANT) && !bus.server_ack && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk)
    if (reset) tcnt <= '0;
    else       tcnt <= (state != GRANT || ack) ? '0 : tcnt + 1'b1;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (bus.enable && |bus.client_rq) ? ARB : IDLE;
      ARB:     state_nx = (bus.enable && found) ? GRANT : IDLE;
      GRANT:   state_nx = ((ack && !more) || tmo) ? RELEASE : GRANT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      wt    <= '0;
      cnt   <= '0;
      gnt   <= '0;
      done  <= '0;
      addr  <= '0;
      req   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= ack ? 4'b0001 << win : 4'b0000;
      if (state == ARB && state_nx == GRANT) begin
        win  <= pick;
        wt   <= (wsel == '0) ? WEIGHT_W'(1) : wsel;
        cnt  <= '0;
        gnt  <= 4'b0001 << pick;
        addr <= pick;
        req  <= 1'b1;
      end
      if (ack) cnt <= cnt + 1'b1;
      if (state == GRANT && state_nx == RELEASE) begin
        gnt <= '0;
        req <= 1'b0;
      end
      if (state == RELEASE) begin
        ptr <= win + 2'd1;
        cnt <= '0;
      end
    end
  end
  assign bus.client_gnt           = gnt;
  assign bus.address_to_be_served = addr;
  assign bus.server_req           = req;
  assign bus.client_done          = done;
  assign bus.busy                 = (state != IDLE);
  assign bus.timeout_err          = tmo;
endmodule
